// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide sharing one 64-bit accumulator, with a start/busy/done handshake.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  MDControl,
    output logic        busy,
    output logic        done,
    output logic [31:0] Result,
    output logic        DivZero
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t      r_state, w_next;
    logic [2:0]  r_op;
    logic [63:0] r_acc;
    logic [31:0] r_operand;
    logic [4:0]  r_count;
    logic        r_neg_res;
    logic        r_neg_rem;
    logic        r_done;
    logic [31:0] r_result;
    logic        r_divzero;

    logic        w_accept, w_is_div, w_signed_a, w_signed_b, w_sign_a, w_sign_b;
    logic [31:0] w_mag_a, w_mag_b;
    logic        w_div_zero, w_overflow, w_fast;
    logic [31:0] w_fast_result;
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_next;
    logic [32:0] w_trial;
    logic [63:0] w_div_next;
    logic [63:0] w_prod;
    logic [31:0] w_quot, w_rem;
    logic [31:0] w_fix_result;

    assign w_accept   = start && (r_state == S_IDLE);
    assign w_is_div   = MDControl[2];
    assign w_signed_a = (MDControl == 3'b001) || (MDControl == 3'b010) ||
                        (MDControl == 3'b100) || (MDControl == 3'b110);
    assign w_signed_b = (MDControl == 3'b001) || (MDControl == 3'b100) ||
                        (MDControl == 3'b110);
    assign w_sign_a   = w_signed_a && A[31];
    assign w_sign_b   = w_signed_b && B[31];
    assign w_mag_a    = w_sign_a ? (~A + 32'd1) : A;
    assign w_mag_b    = w_sign_b ? (~B + 32'd1) : B;

    assign w_div_zero = w_is_div && (B == '0);
    assign w_overflow = ((MDControl == 3'b100) || (MDControl == 3'b110)) &&
                        (A == 32'h8000_0000) && (B == '1);
    assign w_fast     = w_div_zero || w_overflow;

    always_comb begin
        w_fast_result = '0;
        if (w_div_zero)
            w_fast_result = MDControl[1] ? A : '1;
        else if (w_overflow)
            w_fast_result = MDControl[1] ? '0 : 32'h8000_0000;
    end

    // Multiply: add multiplicand into the 33-bit upper slice, then shift right.
    assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_operand} : 33'd0);
    assign w_mul_next = {w_mul_sum, r_acc[31:1]};

    // Divide: r_acc[63:31] is the remainder already shifted left by one.
    assign w_trial    = r_acc[63:31] - {1'b0, r_operand};
    assign w_div_next = w_trial[32] ? {r_acc[62:0], 1'b0}
                                    : {w_trial[31:0], r_acc[30:0], 1'b1};

    assign w_prod = r_neg_res ? (~r_acc + 64'd1) : r_acc;
    assign w_quot = r_neg_res ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
    assign w_rem  = r_neg_rem ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];

    always_comb begin
        w_fix_result = '0;
        case (r_op)
            3'b000:         w_fix_result = w_prod[31:0];
            3'b001, 3'b010,
            3'b011:         w_fix_result = w_prod[63:32];
            3'b100, 3'b101: w_fix_result = w_quot;
            default:        w_fix_result = w_rem;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = w_fast ? S_DONE : S_RUN;
            S_RUN:   if (r_count == '0) w_next = S_FIX;
            S_FIX:   w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op      <= '0;
            r_acc     <= '0;
            r_operand <= '0;
            r_count   <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_done    <= 1'b0;
            r_result  <= '0;
            r_divzero <= 1'b0;
        end else begin
            // done is registered so it lands in the cycle after DONE, when busy is low
            r_done <= (r_state == S_DONE);
            if (w_accept) begin
                r_op      <= MDControl;
                r_neg_res <= w_sign_a ^ w_sign_b;
                r_neg_rem <= w_sign_a;
                r_count   <= 5'd31;
                r_divzero <= w_div_zero;
                r_operand <= w_is_div ? w_mag_b : w_mag_a;
                r_acc     <= {32'd0, (w_is_div ? w_mag_a : w_mag_b)};
                if (w_fast)
                    r_result <= w_fast_result;
            end else if (r_state == S_RUN) begin
                r_acc   <= r_op[2] ? w_div_next : w_mul_next;
                r_count <= r_count - 5'd1;
            end else if (r_state == S_FIX) begin
                r_result <= w_fix_result;
            end
        end
    end

    assign busy    = (r_state != S_IDLE);
    assign done    = r_done;
    assign Result  = r_result;
    assign DivZero = r_divzero;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: results, latency, fast paths,
// handshake behaviour and asynchronous reset.
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  MDControl;
    logic        busy;
    logic        done;
    logic [31:0] Result;
    logic        DivZero;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    muldiv_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .A         (A),
        .B         (B),
        .MDControl (MDControl),
        .busy      (busy),
        .done      (done),
        .Result    (Result),
        .DivZero   (DivZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called #1 after a clock edge with the unit idle. glitch_at >= 1 pulses
    // start (with a divide-by-zero request) for one cycle while busy.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input logic exp_dz, input int exp_lat, input int glitch_at);
        int lat;
        MDControl = op;
        A         = a;
        B         = b;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        A         = $urandom;
        B         = $urandom;
        MDControl = 3'($urandom);
        if (exp_lat > 1)
            check({tag, " busy"}, 32'(busy), 32'd1);
        lat = 0;
        while (!done && lat < 60) begin
            if (lat == glitch_at) begin
                MDControl = 3'b100;
                B         = 32'd0;
                start     = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " result"}, Result, exp_res);
        check({tag, " divzero"}, 32'(DivZero), 32'(exp_dz));
        check({tag, " busy in done"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        check({tag, " done pulse"}, 32'(done), 32'd0);
        check({tag, " result hold"}, Result, exp_res);
    endtask

    initial begin
        int t, first, second, pulses, prev_done, dcount;

        rst = 1'b1; start = 1'b0; A = '0; B = '0; MDControl = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", Result, 32'd0);
        check("reset divzero", 32'(DivZero), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("mul 7x6",        3'b000, 32'd7,          32'd6,          32'd42,         1'b0, 34, -1);
        run_op("mul -1x-1",      3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 34, -1);
        run_op("mulhu -1x-1",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 34, -1);
        run_op("mulh -1x-1",     3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 34, -1);
        run_op("mulhsu -1x2",    3'b010, 32'hFFFF_FFFF, 32'd2,          32'hFFFF_FFFF, 1'b0, 34, -1);
        run_op("mulh min^2",     3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 34, -1);
        run_op("mulhsu min",     3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 34, -1);
        run_op("div -7/2",       3'b100, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 1'b0, 34, -1);
        run_op("rem -7/2",       3'b110, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 1'b0, 34, -1);
        run_op("divu -7/2",      3'b101, 32'hFFFF_FFF9, 32'd2,          32'h7FFF_FFFC, 1'b0, 34, -1);
        run_op("div 7/-2",       3'b100, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 34, -1);
        run_op("rem 7/-2",       3'b110, 32'd7,          32'hFFFF_FFFE, 32'd1,          1'b0, 34, -1);
        run_op("divu 100/7",     3'b101, 32'd100,        32'd7,          32'd14,         1'b0, 34, -1);
        run_op("remu 100/7",     3'b111, 32'd100,        32'd7,          32'd2,          1'b0, 34, -1);
        run_op("div0 div",       3'b100, 32'h1234,       32'd0,          32'hFFFF_FFFF, 1'b1, 1,  -1);
        run_op("div0 rem",       3'b110, 32'h1234,       32'd0,          32'h0000_1234, 1'b1, 1,  -1);
        run_op("div0 divu",      3'b101, 32'h1234,       32'd0,          32'hFFFF_FFFF, 1'b1, 1,  -1);
        run_op("div0 remu",      3'b111, 32'h1234,       32'd0,          32'h0000_1234, 1'b1, 1,  -1);
        run_op("ovf div",        3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1,  -1);
        run_op("ovf rem",        3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1,  -1);
        run_op("divu min/-1",    3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 34, -1);
        run_op("start in busy",  3'b000, 32'd7,          32'd6,          32'd42,         1'b0, 34, 5);

        // start held high: done pulses 35 cycles apart, never back to back
        MDControl = 3'b000; A = 32'd3; B = 32'd4; start = 1'b1;
        first = -1; second = -1; pulses = 0; prev_done = 0; dcount = 0;
        for (t = 1; t <= 75; t++) begin
            @(posedge clk); #1;
            if (done) begin
                pulses++;
                if (first < 0) first = t;
                else if (second < 0) second = t;
                if (prev_done != 0) dcount++;
            end
            prev_done = int'(done);
        end
        start = 1'b0;
        check("held first done", 32'(first), 32'd35);
        check("held spacing", 32'(second - first), 32'd35);
        check("held pulses", 32'(pulses), 32'd2);
        t = 0;
        while (!done && t < 60) begin
            @(posedge clk); #1;
            t++;
        end
        check("held drain done", 32'(done), 32'd1);
        check("held result", Result, 32'd12);
        @(posedge clk); #1;
        if (done) dcount++;
        check("held double done", 32'(dcount), 32'd0);

        // asynchronous reset in the middle of RUN
        MDControl = 3'b000; A = 32'd9; B = 32'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst result", Result, 32'd0);
        check("midrst done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        check("midrst no done", 32'(pulses), 32'd0);
        check("midrst result hold", Result, 32'd0);
        run_op("mul 3x5 after rst", 3'b000, 32'd3, 32'd5, 32'd15, 1'b0, 34, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
